sram_arbiter: RTL and testbench

Time-slot arbiter between the video layer fetch channels, a single host write port, and the external asynchronous 16-bit SRAM. It is the parametrised successor to the fixed single-client SRAM hookup under the video top level. Channel count, address/data width and access length are generics. A per-layer enable mask gates arbitration, and a starvation counter bounds host write latency. The block sits between the layer fetch engines and the top-level SRAM pin drivers (active-high controls, inverted at the pads).

---
 rtl/sram_arb_pkg.sv | 42 ++++
 rtl/sram_arbiter_rr.sv | 44 ++++
 rtl/sram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types, default generics and the round-robin helper for sram_arbiter.
//   state_t       : access FSM states
//   DEF_*         : default generic values
//   rr_next()     : one-hot round-robin winner over up to MAX_CH channels
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    TURN
  } state_t;

  localparam int unsigned MAX_CH            = 8;
  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_AW            = 18;
  localparam int unsigned DEF_DW            = 16;
  localparam int unsigned DEF_ACCESS_CYCLES = 3;
  localparam int unsigned DEF_WR_STARVE     = 4;

  // Search starts at last+1 and wraps at n-1; the final probe (k == n) is
  // 'last' itself, so a lone requester can win repeatedly.
  function automatic logic [MAX_CH-1:0] rr_next(input logic [MAX_CH-1:0] mask,
                                                input logic [2:0]        last,
                                                input int unsigned       n);
    logic        found;
    int unsigned idx;
    rr_next = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      if (k <= n) begin
        idx = 32'(last) + k;
        if (idx >= n) idx = idx - n;
        if (!found && mask[idx[2:0]]) begin
          rr_next[idx[2:0]] = 1'b1;
          found             = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot winner among i_req, with the
// last granted channel registered when i_update is high.
//   clk, rst_n : clock, async active-low reset (last channel -> NUM_CH-1)
//   i_req      : eligible request vector
//   i_update   : winner is being granted this edge
//   o_gnt      : one-hot winner (zero when no request)
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_update,
  output logic [NUM_CH-1:0] o_gnt
);

  logic [2:0]        r_last;
  logic [MAX_CH-1:0] w_req8;
  logic [MAX_CH-1:0] w_win8;
  logic [2:0]        w_win_idx;

  always_comb begin
    w_req8                = '0;
    w_req8[NUM_CH-1:0]    = i_req;
    w_win8                = rr_next(w_req8, r_last, NUM_CH);
    w_win_idx             = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (w_win8[i]) w_win_idx = 3'(i);
    end
  end

  assign o_gnt = w_win8[NUM_CH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 3'(NUM_CH - 1);
    end else if (i_update) begin
      r_last <= w_win_idx;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Time-slot arbiter between NUM_CH layer read channels, one host write port
// and an asynchronous SRAM. Each access lasts ACCESS_CYCLES clocks; a write
// is followed by one bus turnaround cycle. Pad tristate is external, enabled
// by o_sram_drive.
//   i_layer_en/i_rd_req/i_rd_addr : read channels (addr packed, ch i at [i*AW +: AW])
//   o_rd_gnt/o_rd_valid/o_rd_data : one-hot grant/valid pulses, shared data
//   i_wr_*/o_wr_gnt/o_wr_done     : host write port
//   o_sram_* / i_sram_din         : SRAM pins (active-high controls)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned AW            = DEF_AW,
  parameter int unsigned DW            = DEF_DW,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int unsigned WR_STARVE     = DEF_WR_STARVE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    i_layer_en,
  input  logic [NUM_CH-1:0]    i_rd_req,
  input  logic [NUM_CH*AW-1:0] i_rd_addr,
  output logic [NUM_CH-1:0]    o_rd_gnt,
  output logic [NUM_CH-1:0]    o_rd_valid,
  output logic [DW-1:0]        o_rd_data,
  input  logic                 i_wr_req,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [DW-1:0]        i_wr_data,
  input  logic [DW/8-1:0]      i_wr_be,
  output logic                 o_wr_gnt,
  output logic                 o_wr_done,
  output logic [AW-1:0]        o_sram_addr,
  output logic [DW-1:0]        o_sram_dout,
  input  logic [DW-1:0]        i_sram_din,
  output logic                 o_sram_ce,
  output logic                 o_sram_oe,
  output logic                 o_sram_we,
  output logic                 o_sram_drive,
  output logic [DW/8-1:0]      o_sram_be
);

  localparam int unsigned NBE = DW / 8;
  localparam int unsigned CW  = $clog2(ACCESS_CYCLES + 1);
  localparam int unsigned SW  = (WR_STARVE > 0) ? $clog2(WR_STARVE + 1) : 1;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cyc, w_cyc_nxt;
  logic [SW-1:0]     r_starve;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [NBE-1:0]    r_be;
  logic [NUM_CH-1:0] r_cur;
  logic [NUM_CH-1:0] r_rd_gnt;
  logic [NUM_CH-1:0] r_rd_valid;
  logic [DW-1:0]     r_rd_data;
  logic              r_wr_gnt;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_rr_win;
  logic [AW-1:0]     w_rd_addr;
  logic              w_last, w_decide, w_pick_wr, w_pick_rd;

  assign w_elig    = i_rd_req & i_layer_en;
  assign w_last    = (r_cyc == CW'(ACCESS_CYCLES));
  assign w_decide  = (r_state == IDLE) || (r_state == READ && w_last);
  assign w_pick_wr = w_decide && i_wr_req &&
                     (!(|w_elig) || (r_starve == SW'(WR_STARVE)));
  assign w_pick_rd = w_decide && !w_pick_wr && (|w_elig);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_elig),
    .i_update (w_pick_rd),
    .o_gnt    (w_rr_win)
  );

  always_comb begin
    w_rd_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_rr_win[i]) w_rd_addr = w_rd_addr | i_rd_addr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = '0;
    case (r_state)
      IDLE, READ: begin
        if (w_pick_wr) begin
          w_state_nxt = WRITE;
          w_cyc_nxt   = CW'(1);
        end else if (w_pick_rd) begin
          w_state_nxt = READ;
          w_cyc_nxt   = CW'(1);
        end else if (w_decide) begin
          w_state_nxt = IDLE;
        end else begin
          w_cyc_nxt   = r_cyc + CW'(1);
        end
      end
      WRITE: begin
        if (w_last) w_state_nxt = TURN;
        else        w_cyc_nxt   = r_cyc + CW'(1);
      end
      TURN:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_cur      <= '0;
      r_rd_gnt   <= '0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_wr_gnt   <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_rd_gnt   <= w_pick_rd ? w_rr_win : '0;
      r_wr_gnt   <= w_pick_wr;
      r_rd_valid <= (r_state == READ && w_last) ? r_cur : '0;
      if (r_state == READ && w_last) r_rd_data <= i_sram_din;
      if (w_pick_wr) begin
        r_addr  <= i_wr_addr;
        r_wdata <= i_wr_data;
        r_be    <= i_wr_be;
      end else if (w_pick_rd) begin
        r_addr  <= w_rd_addr;
        r_cur   <= w_rr_win;
      end
      // Counts reads that overtook a pending write; reset once it wins or leaves.
      if (!i_wr_req || w_pick_wr)                            r_starve <= '0;
      else if (w_pick_rd && r_starve != SW'(WR_STARVE))     r_starve <= r_starve + SW'(1);
    end
  end

  // Controls decode straight from registered state so reset drops them at once.
  always_comb begin
    o_sram_ce    = (r_state == READ) || (r_state == WRITE);
    o_sram_oe    = (r_state == READ);
    o_sram_drive = (r_state == WRITE);
    o_sram_we    = (r_state == WRITE) && (r_cyc >= CW'(2)) &&
                   (r_cyc <= CW'(ACCESS_CYCLES - 1));
    o_sram_be    = '0;
    if (r_state == READ)  o_sram_be = '1;
    if (r_state == WRITE) o_sram_be = r_be;
  end

  assign o_wr_done   = (r_state == WRITE) && w_last;
  assign o_sram_addr = r_addr;
  assign o_sram_dout = r_wdata;
  assign o_rd_gnt    = r_rd_gnt;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_wr_gnt    = r_wr_gnt;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM.
module tb_sram_arbiter;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned AW     = 18;
  localparam int unsigned DW     = 16;
  localparam int unsigned NBE    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_CH-1:0]    i_layer_en, i_rd_req;
  logic [NUM_CH*AW-1:0] i_rd_addr;
  logic [NUM_CH-1:0]    o_rd_gnt, o_rd_valid;
  logic [DW-1:0]        o_rd_data;
  logic                 i_wr_req;
  logic [AW-1:0]        i_wr_addr;
  logic [DW-1:0]        i_wr_data;
  logic [NBE-1:0]       i_wr_be;
  logic                 o_wr_gnt, o_wr_done;
  logic [AW-1:0]        o_sram_addr;
  logic [DW-1:0]        o_sram_dout, i_sram_din;
  logic                 o_sram_ce, o_sram_oe, o_sram_we, o_sram_drive;
  logic [NBE-1:0]       o_sram_be;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter #(
    .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .ACCESS_CYCLES(3), .WR_STARVE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_layer_en(i_layer_en), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_rd_gnt(o_rd_gnt), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_wr_be(i_wr_be), .o_wr_gnt(o_wr_gnt), .o_wr_done(o_wr_done),
    .o_sram_addr(o_sram_addr), .o_sram_dout(o_sram_dout), .i_sram_din(i_sram_din),
    .o_sram_ce(o_sram_ce), .o_sram_oe(o_sram_oe), .o_sram_we(o_sram_we),
    .o_sram_drive(o_sram_drive), .o_sram_be(o_sram_be)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, byte-lane write latched at clock edge.
  assign i_sram_din = (o_sram_ce && o_sram_oe) ? mem[o_sram_addr] : 16'hDEAD;
  always @(posedge clk) begin
    if (o_sram_ce && o_sram_we) begin
      if (o_sram_be[0]) mem[o_sram_addr][7:0]  <= o_sram_dout[7:0];
      if (o_sram_be[1]) mem[o_sram_addr][15:8] <= o_sram_dout[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("drv_oe",   32'(o_sram_drive & o_sram_oe), 32'd0);
      chk("gnt_1hot", 32'($onehot0(o_rd_gnt)), 32'd1);
      chk("vld_1hot", 32'($onehot0(o_rd_valid)), 32'd1);
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    i_layer_en = '0;
    i_rd_req   = '0;
    i_wr_req   = 1'b0;
    i_wr_be    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[18'h00123] = 16'hBEEF;
    i_rd_addr = '0;
    i_wr_addr = '0;
    i_wr_data = '0;

    // Reset values
    rst_n = 1'b0; i_layer_en = '0; i_rd_req = '0; i_wr_req = 1'b0; i_wr_be = '0;
    @(negedge clk);
    chk("rst_gnt",  32'(o_rd_gnt), 32'd0);
    chk("rst_vld",  32'(o_rd_valid), 32'd0);
    chk("rst_data", 32'(o_rd_data), 32'd0);
    chk("rst_wr",   32'({o_wr_gnt, o_wr_done}), 32'd0);
    chk("rst_ctl",  32'({o_sram_ce, o_sram_oe, o_sram_we, o_sram_drive}), 32'd0);
    chk("rst_addr", 32'(o_sram_addr), 32'd0);
    chk("rst_be",   32'(o_sram_be), 32'd0);
    do_reset();

    // Single read on ch2; layer_en drops mid-access but rd_valid still comes
    i_layer_en = 4'hF;
    i_rd_addr[2*AW +: AW] = 18'h00123;
    i_rd_req = 4'b0100;
    @(negedge clk);
    chk("rd1_gnt",  32'(o_rd_gnt), 32'h4);
    chk("rd1_addr", 32'(o_sram_addr), 32'h00123);
    chk("rd1_ceoe", 32'({o_sram_ce, o_sram_oe}), 32'h3);
    chk("rd1_be",   32'(o_sram_be), 32'h3);
    i_rd_req = '0;
    i_layer_en = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rd1_novld", 32'(o_rd_valid), 32'd0);
    end
    @(negedge clk);
    chk("rd1_vld",  32'(o_rd_valid), 32'h4);
    chk("rd1_data", 32'(o_rd_data), 32'hBEEF);
    chk("rd1_idle", 32'(o_sram_ce), 32'd0);

    // Round-robin, then masked to channels 1 and 3
    do_reset();
    begin
      logic [3:0] exp_rr [8];
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
      i_layer_en = 4'hF;
      i_rd_req   = 4'hF;
      for (int g = 0; g < 8; g++) begin
        if (g > 0) begin
          repeat (2) begin
            @(negedge clk);
            chk("rr_gap", 32'(o_rd_gnt), 32'd0);
            chk("rr_ce",  32'(o_sram_ce), 32'd1);
          end
        end
        @(negedge clk);
        chk($sformatf("rr_gnt%0d", g), 32'(o_rd_gnt), 32'(exp_rr[g]));
        chk("rr_ce_b2b", 32'(o_sram_ce), 32'd1);
        if (g > 0) chk($sformatf("rr_vld%0d", g), 32'(o_rd_valid), 32'(exp_rr[g-1]));
        if (g == 3) i_layer_en = 4'b1010;
      end
      i_rd_req = '0;
      repeat (4) @(negedge clk);
    end

    // Write starvation bound
    do_reset();
    mem[18'h00456] = 16'h0000;
    i_layer_en = 4'hF;
    i_rd_req   = 4'hF;
    i_wr_req   = 1'b1;
    i_wr_be    = 2'b10;
    i_wr_addr  = 18'h00456;
    i_wr_data  = 16'hA5C3;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) repeat (2) begin
        @(negedge clk);
        chk("st_nowr", 32'(o_wr_gnt), 32'd0);
      end
      @(negedge clk);
      chk($sformatf("st_rd%0d", g), 32'(o_rd_gnt), 32'(1 << g));
      chk("st_wr0", 32'(o_wr_gnt), 32'd0);
    end
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("st_wgnt", 32'(o_wr_gnt), 32'd1);
    chk("st_rgnt", 32'(o_rd_gnt), 32'd0);
    chk("st_vld3", 32'(o_rd_valid), 32'h8);
    chk("st_c1",   32'({o_sram_ce, o_sram_oe, o_sram_we, o_sram_drive}), 32'b1001);
    chk("st_be",   32'(o_sram_be), 32'h2);
    i_wr_req = 1'b0;
    @(negedge clk);
    chk("st_c2",   32'({o_sram_ce, o_sram_oe, o_sram_we, o_sram_drive}), 32'b1011);
    chk("st_be2",  32'(o_sram_be), 32'h2);
    @(negedge clk);
    chk("st_c3",   32'({o_sram_ce, o_sram_oe, o_sram_we, o_sram_drive}), 32'b1001);
    chk("st_done", 32'(o_wr_done), 32'd1);
    @(negedge clk);
    chk("st_turn", 32'({o_sram_ce, o_sram_oe, o_sram_we, o_sram_drive}), 32'd0);
    chk("st_tdone", 32'(o_wr_done), 32'd0);
    chk("st_tgnt", 32'(o_rd_gnt), 32'd0);
    @(negedge clk);
    chk("st_idle", 32'(o_rd_gnt), 32'd0);
    @(negedge clk);
    chk("st_resume", 32'(o_rd_gnt), 32'h1);
    chk("st_mem", 32'(mem[18'h00456]), 32'hA500);
    i_rd_req = '0;
    repeat (4) @(negedge clk);

    // Idle write, then a write with no byte lanes
    do_reset();
    i_wr_req  = 1'b1;
    i_wr_addr = 18'h3FFFF;
    i_wr_data = 16'h5A5A;
    i_wr_be   = 2'b11;
    @(negedge clk);
    chk("iw_gnt", 32'(o_wr_gnt), 32'd1);
    chk("iw_addr", 32'(o_sram_addr), 32'h3FFFF);
    i_wr_req = 1'b0;
    @(negedge clk);
    chk("iw_we", 32'(o_sram_we), 32'd1);
    chk("iw_nodone", 32'(o_wr_done), 32'd0);
    @(negedge clk);
    chk("iw_done", 32'(o_wr_done), 32'd1);
    @(negedge clk);
    chk("iw_turn", 32'(o_sram_ce), 32'd0);
    chk("iw_mem", 32'(mem[18'h3FFFF]), 32'h5A5A);
    @(negedge clk);
    i_wr_req  = 1'b1;
    i_wr_data = 16'hFFFF;
    i_wr_be   = 2'b00;
    @(negedge clk);
    chk("be0_gnt", 32'(o_wr_gnt), 32'd1);
    chk("be0_be", 32'(o_sram_be), 32'd0);
    i_wr_req = 1'b0;
    @(negedge clk);
    chk("be0_be2", 32'(o_sram_be), 32'd0);
    @(negedge clk);
    chk("be0_done", 32'(o_wr_done), 32'd1);
    chk("be0_mem", 32'(mem[18'h3FFFF]), 32'h5A5A);
    repeat (3) @(negedge clk);

    // Reset asserted in READ cycle 2
    do_reset();
    i_layer_en = 4'hF;
    i_rd_addr[0 +: AW] = 18'h00123;
    i_rd_req = 4'b0001;
    @(negedge clk);
    chk("ra_gnt", 32'(o_rd_gnt), 32'h1);
    i_rd_req = '0;
    @(negedge clk);
    chk("ra_c2", 32'({o_sram_ce, o_sram_oe}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_ctl", 32'({o_sram_ce, o_sram_oe}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("ra_novld", 32'(o_rd_valid), 32'd0);
    end
    rst_n    = 1'b1;
    i_rd_req = 4'b0011;
    @(negedge clk);
    chk("ra_first", 32'(o_rd_gnt), 32'h1);
    chk("ra_novld2", 32'(o_rd_valid), 32'd0);
    i_rd_req = '0;
    repeat (4) begin
      @(negedge clk);
      chk("ra_novld3", 32'(o_rd_valid & 4'b1110), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
